ysyx_23060332_lsu: RTL and testbench

YSYX_23060332_LSU -- requirements
Module: ysyx_23060332_lsu

---
 rtl/ysyx_23060332_lsu_pkg.sv | 39 +++
 rtl/ysyx_23060332_lsu_if.sv | 46 ++++
 rtl/ysyx_23060332_lsu_align.sv | 38 +++
 rtl/ysyx_23060332_lsu.sv | 177 +++++++++++++++++
 tb/tb_ysyx_23060332_lsu.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_23060332_lsu_pkg.sv
// rtl/ysyx_23060332_lsu_pkg.sv - shared LSU widths, FSM states, func3 constants and access checks
// Sub-word loads/stores are enabled by defining YSYX_23060332_LSU_SUBWORD_EN.
package ysyx_23060332_lsu_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic func3_supported(input logic is_store, input logic [2:0] func3);
    logic st_ok;
    logic ld_ok;
`ifdef YSYX_23060332_LSU_SUBWORD_EN
    st_ok = (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W);
    ld_ok = st_ok || (func3 == F3_BU) || (func3 == F3_HU);
`else
    st_ok = (func3 == F3_W);
    ld_ok = (func3 == F3_W);
`endif
    return is_store ? st_ok : ld_ok;
  endfunction

  // size is func3[1:0]: 00 byte, 01 half, 10 word
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == 2'b01) && addr_lo[0]) || ((size == 2'b10) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/ysyx_23060332_lsu_if.sv
// rtl/ysyx_23060332_lsu_if.sv - execute-side, memory-bus and writeback signals of the LSU
interface ysyx_23060332_lsu_if;
  import ysyx_23060332_lsu_pkg::*;

  logic            ex_valid;
  logic            ex_ready;
  logic            ex_wen;
  logic            ex_ren;
  logic [AW-1:0]   ex_addr;
  logic [XLEN-1:0] ex_wdata;
  logic [2:0]      ex_func3;
  logic [4:0]      ex_rd;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_req_we;
  logic [AW-1:0]   mem_req_addr;
  logic [XLEN-1:0] mem_req_wdata;
  logic [3:0]      mem_req_wstrb;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_rdata;
  logic            mem_rsp_err;

  logic            wb_valid;
  logic [4:0]      wb_waddr;
  logic [XLEN-1:0] wb_wdata;
  logic            lsu_err;
  logic            busy;

  modport slave (
    input  ex_valid, ex_wen, ex_ren, ex_addr, ex_wdata, ex_func3, ex_rd,
    output ex_ready,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
    output wb_valid, wb_waddr, wb_wdata, lsu_err, busy
  );

  modport master (
    output ex_valid, ex_wen, ex_ren, ex_addr, ex_wdata, ex_func3, ex_rd,
    input  ex_ready,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
    input  wb_valid, wb_waddr, wb_wdata, lsu_err, busy
  );

endinterface

// File: rtl/ysyx_23060332_lsu_align.sv
// rtl/ysyx_23060332_lsu_align.sv - store lane placement and load data extraction
module ysyx_23060332_lsu_align
  import ysyx_23060332_lsu_pkg::*;
(
  input  logic [1:0]      st_size,
  input  logic [1:0]      st_addr_lo,
  input  logic [XLEN-1:0] st_wdata,
  output logic [3:0]      st_wstrb,
  output logic [XLEN-1:0] st_wdata_sh,
  input  logic [2:0]      ld_func3,
  input  logic [1:0]      ld_addr_lo,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_data
);

  logic [XLEN-1:0] ld_sh;

  always_comb begin
    st_wdata_sh = st_wdata << {st_addr_lo, 3'b000};
    case (st_size)
      2'b00:   st_wstrb = 4'b0001 << st_addr_lo;
      2'b01:   st_wstrb = 4'b0011 << st_addr_lo;
      default: st_wstrb = 4'b1111;
    endcase
  end

  always_comb begin
    ld_sh = ld_rdata >> {ld_addr_lo, 3'b000};
    case (ld_func3)
      F3_B:    ld_data = {{24{ld_sh[7]}}, ld_sh[7:0]};
      F3_H:    ld_data = {{16{ld_sh[15]}}, ld_sh[15:0]};
      F3_BU:   ld_data = {24'd0, ld_sh[7:0]};
      F3_HU:   ld_data = {16'd0, ld_sh[15:0]};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_23060332_lsu.sv
// rtl/ysyx_23060332_lsu.sv - load/store unit: IDLE -> REQ -> WAIT -> DONE with timeout and error pulse
module ysyx_23060332_lsu
  import ysyx_23060332_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                  clk,
  input logic                  rst,
  ysyx_23060332_lsu_if.slave   bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_e      state_q, state_d;
  logic            is_store_q, is_store_d;
  logic [2:0]      func3_q, func3_d;
  logic [1:0]      addr_lo_q, addr_lo_d;
  logic [4:0]      rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ex_ready_q, ex_ready_d;
  logic            busy_q, busy_d;
  logic            mem_req_valid_q, mem_req_valid_d;
  logic            mem_req_we_q, mem_req_we_d;
  logic [AW-1:0]   mem_req_addr_q, mem_req_addr_d;
  logic [XLEN-1:0] mem_req_wdata_q, mem_req_wdata_d;
  logic [3:0]      mem_req_wstrb_q, mem_req_wstrb_d;
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_waddr_q, wb_waddr_d;
  logic [XLEN-1:0] wb_wdata_q, wb_wdata_d;
  logic            lsu_err_q, lsu_err_d;

  logic [3:0]      st_wstrb;
  logic [XLEN-1:0] st_wdata_sh;
  logic [XLEN-1:0] ld_data;

  // Store lanes come from the live execute inputs at capture; loads use the captured func3/offset.
  ysyx_23060332_lsu_align u_align (
    .st_size     (bus.ex_func3[1:0]),
    .st_addr_lo  (bus.ex_addr[1:0]),
    .st_wdata    (bus.ex_wdata),
    .st_wstrb    (st_wstrb),
    .st_wdata_sh (st_wdata_sh),
    .ld_func3    (func3_q),
    .ld_addr_lo  (addr_lo_q),
    .ld_rdata    (bus.mem_rsp_rdata),
    .ld_data     (ld_data)
  );

  always_comb begin
    state_d         = state_q;
    is_store_d      = is_store_q;
    func3_d         = func3_q;
    addr_lo_d       = addr_lo_q;
    rd_d            = rd_q;
    cnt_d           = cnt_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_we_d    = mem_req_we_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_req_wdata_d = mem_req_wdata_q;
    mem_req_wstrb_d = mem_req_wstrb_q;
    wb_valid_d      = 1'b0;
    wb_waddr_d      = 5'd0;
    wb_wdata_d      = '0;
    lsu_err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.ex_valid && (bus.ex_wen || bus.ex_ren)) begin
          is_store_d = bus.ex_wen;
          func3_d    = bus.ex_func3;
          addr_lo_d  = bus.ex_addr[1:0];
          rd_d       = bus.ex_rd;
          if (!func3_supported(bus.ex_wen, bus.ex_func3) ||
              misaligned(bus.ex_func3[1:0], bus.ex_addr[1:0])) begin
            state_d   = S_DONE;
            lsu_err_d = 1'b1;
          end else begin
            state_d         = S_REQ;
            mem_req_valid_d = 1'b1;
            mem_req_we_d    = bus.ex_wen;
            mem_req_addr_d  = {bus.ex_addr[AW-1:2], 2'b00};
            mem_req_wdata_d = bus.ex_wen ? st_wdata_sh : '0;
            mem_req_wstrb_d = bus.ex_wen ? st_wstrb : 4'd0;
          end
        end
      end
      S_REQ: begin
        if (bus.mem_req_ready) begin
          state_d         = S_WAIT;
          cnt_d           = '0;
          mem_req_valid_d = 1'b0;
          mem_req_we_d    = 1'b0;
          mem_req_addr_d  = '0;
          mem_req_wdata_d = '0;
          mem_req_wstrb_d = 4'd0;
        end
      end
      S_WAIT: begin
        // A response in the final counted cycle takes priority over the timeout.
        if (bus.mem_rsp_valid) begin
          state_d = S_DONE;
          if (bus.mem_rsp_err) begin
            lsu_err_d = 1'b1;
          end else if (!is_store_q) begin
            wb_valid_d = 1'b1;
            wb_waddr_d = rd_q;
            wb_wdata_d = (rd_q == 5'd0) ? '0 : ld_data;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_DONE;
          lsu_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ex_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      is_store_q      <= 1'b0;
      func3_q         <= 3'd0;
      addr_lo_q       <= 2'd0;
      rd_q            <= 5'd0;
      cnt_q           <= '0;
      ex_ready_q      <= 1'b1;
      busy_q          <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_req_we_q    <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_wdata_q <= '0;
      mem_req_wstrb_q <= 4'd0;
      wb_valid_q      <= 1'b0;
      wb_waddr_q      <= 5'd0;
      wb_wdata_q      <= '0;
      lsu_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      is_store_q      <= is_store_d;
      func3_q         <= func3_d;
      addr_lo_q       <= addr_lo_d;
      rd_q            <= rd_d;
      cnt_q           <= cnt_d;
      ex_ready_q      <= ex_ready_d;
      busy_q          <= busy_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_we_q    <= mem_req_we_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_req_wdata_q <= mem_req_wdata_d;
      mem_req_wstrb_q <= mem_req_wstrb_d;
      wb_valid_q      <= wb_valid_d;
      wb_waddr_q      <= wb_waddr_d;
      wb_wdata_q      <= wb_wdata_d;
      lsu_err_q       <= lsu_err_d;
    end
  end

  assign bus.ex_ready      = ex_ready_q;
  assign bus.busy          = busy_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_we    = mem_req_we_q;
  assign bus.mem_req_addr  = mem_req_addr_q;
  assign bus.mem_req_wdata = mem_req_wdata_q;
  assign bus.mem_req_wstrb = mem_req_wstrb_q;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_waddr      = wb_waddr_q;
  assign bus.wb_wdata      = wb_wdata_q;
  assign bus.lsu_err       = lsu_err_q;

endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// tb/tb_ysyx_23060332_lsu.sv - scoreboard bench for ysyx_23060332_lsu with a queue-based reference model
module tb_ysyx_23060332_lsu;

  localparam int T = 20;
  localparam int K_REQ = 0;
  localparam int K_WB  = 1;
  localparam int K_ERR = 2;

  typedef struct {
    int          kind;
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [4:0]  rd;
    logic [31:0] data;
  } ev_t;

  bit   clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  ev_t  expq[$];

  ysyx_23060332_lsu_if bus();

  ysyx_23060332_lsu #(.TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void push_ev(input int kind, input int c, input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] wstrb,
                                  input logic [4:0] rd, input logic [31:0] data);
    ev_t e;
    e.kind = kind; e.cyc = c; e.we = we; e.addr = addr;
    e.wdata = wdata; e.wstrb = wstrb; e.rd = rd; e.data = data;
    expq.push_back(e);
  endfunction

  function automatic bit model_supported(input bit st, input logic [2:0] f3);
`ifdef YSYX_23060332_LSU_SUBWORD_EN
    if (st) return f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2;
    return f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5;
`else
    return f3 == 3'd2;
`endif
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] rdata);
    logic [31:0] w;
    int v;
    w = rdata >> (8 * lo);
    case (f3)
      3'd0: begin v = int'(w & 32'hFF);   if (v >= 128)   v -= 256;   return 32'(v); end
      3'd1: begin v = int'(w & 32'hFFFF); if (v >= 32768) v -= 65536; return 32'(v); end
      3'd4: return w & 32'hFF;
      3'd5: return w & 32'hFFFF;
      default: return rdata;
    endcase
  endfunction

  // Monitor: compares every DUT output event against the head of the expectation queue.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.mem_req_valid) begin
        if (expq.size() != 0 && expq[0].kind == K_REQ) begin
          chk("req_we", bus.mem_req_we, expq[0].we);
          chk("req_addr", bus.mem_req_addr, expq[0].addr);
          if (expq[0].we) begin
            chk("req_wdata", bus.mem_req_wdata, expq[0].wdata);
            chk("req_wstrb", bus.mem_req_wstrb, expq[0].wstrb);
          end
          chk("req_ex_ready_low", bus.ex_ready, 1'b0);
          if (bus.mem_req_ready) begin
            chk("req_cycle", 32'(cyc), 32'(expq[0].cyc));
            expq.delete(0);
          end
        end else begin
          chk("req_spurious", bus.mem_req_valid, 1'b0);
        end
      end
      if (bus.wb_valid) begin
        if (expq.size() != 0 && expq[0].kind == K_WB) begin
          chk("wb_waddr", bus.wb_waddr, expq[0].rd);
          chk("wb_wdata", bus.wb_wdata, expq[0].data);
          chk("wb_cycle", 32'(cyc), 32'(expq[0].cyc));
          chk("wb_no_err", bus.lsu_err, 1'b0);
          expq.delete(0);
        end else begin
          chk("wb_spurious", bus.wb_valid, 1'b0);
        end
      end
      if (bus.lsu_err) begin
        if (expq.size() != 0 && expq[0].kind == K_ERR) begin
          chk("err_cycle", 32'(cyc), 32'(expq[0].cyc));
          chk("err_no_wb", bus.wb_valid, 1'b0);
          expq.delete(0);
        end else begin
          chk("err_spurious", bus.lsu_err, 1'b0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_ex();
    bus.ex_valid = 1'b0;
    bus.ex_addr  = $urandom;
    bus.ex_wdata = $urandom;
    bus.ex_func3 = 3'($urandom);
    bus.ex_rd    = 5'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!bus.ex_ready && n < 400) begin
      tick();
      n++;
    end
    if (!bus.ex_ready) chk("idle_wait_expired", bus.ex_ready, 1'b1);
    chk("idle_busy", bus.busy, 1'b0);
  endtask

  // mode: 0 normal response, 1 bus error response, 2 no response
  task automatic run_txn(input bit wen, input bit ren, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, input logic [4:0] rd, input int rdly, input int mode,
                         input int dly, input logic [31:0] rdata);
    bit st;
    int acc;
    int nb;
    logic [1:0] lo;
    wait_idle();
    st = wen;
    lo = addr[1:0];
    nb = nbytes(f3);
    bus.ex_valid = 1'b1; bus.ex_wen = wen; bus.ex_ren = ren;
    bus.ex_addr = addr; bus.ex_wdata = wdata; bus.ex_func3 = f3; bus.ex_rd = rd;
    acc = cyc;
    if (!model_supported(st, f3) || (int'(lo) % nb) != 0) begin
      push_ev(K_ERR, acc + 1, 1'b0, 0, 0, 0, 0, 0);
      tick();
      scramble_ex();
      wait_idle();
      return;
    end
    push_ev(K_REQ, acc + 1 + rdly, st, {addr[31:2], 2'b00}, wdata << (8 * lo),
            4'(((1 << nb) - 1) << lo), 0, 0);
    if (mode == 2)      push_ev(K_ERR, acc + 2 + rdly + T, 1'b0, 0, 0, 0, 0, 0);
    else if (mode == 1) push_ev(K_ERR, acc + 3 + rdly + dly, 1'b0, 0, 0, 0, 0, 0);
    else if (!st)       push_ev(K_WB, acc + 3 + rdly + dly, 1'b0, 0, 0, 0, rd,
                                (rd == 5'd0) ? 32'd0 : model_load(f3, lo, rdata));
    tick();
    scramble_ex();
    chk("busy_in_req", bus.busy, 1'b1);
    for (int i = 0; i < rdly; i++) begin
      chk("req_hold", bus.mem_req_valid, 1'b1);
      bus.mem_rsp_valid = 1'($urandom);
      bus.mem_rsp_err   = 1'b1;
      tick();
    end
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_err   = 1'b0;
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    if (mode != 2) begin
      repeat (dly) tick();
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_err   = (mode == 1);
      bus.mem_rsp_rdata = rdata;
      tick();
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_err   = 1'b0;
      bus.mem_rsp_rdata = $urandom;
    end
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 50000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    rst = 1'b1;
    bus.ex_valid = 1'b0; bus.ex_wen = 1'b0; bus.ex_ren = 1'b0;
    bus.ex_addr = '0; bus.ex_wdata = '0; bus.ex_func3 = '0; bus.ex_rd = '0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = '0; bus.mem_rsp_err = 1'b0;
    repeat (3) tick();
    chk("rst_ex_ready", bus.ex_ready, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_req_valid", bus.mem_req_valid, 1'b0);
    chk("rst_wb_valid", bus.wb_valid, 1'b0);
    chk("rst_lsu_err", bus.lsu_err, 1'b0);
    chk("rst_req_addr", bus.mem_req_addr, 32'd0);
    chk("rst_req_wstrb", bus.mem_req_wstrb, 4'd0);
    chk("rst_wb_wdata", bus.wb_wdata, 32'd0);
    rst = 1'b0;
    tick();

    run_txn(1'b0, 1'b1, 32'h8000_0004, 32'h0, 3'd2, 5'd5, 0, 0, 0, 32'hDEAD_BEEF);
    run_txn(1'b0, 1'b1, 32'h8000_0003, 32'h0, 3'd0, 5'd6, 0, 0, 0, 32'h8011_2233);
    run_txn(1'b0, 1'b1, 32'h8000_0003, 32'h0, 3'd4, 5'd7, 0, 0, 1, 32'h8011_2233);
    run_txn(1'b1, 1'b0, 32'h8000_0002, 32'h0000_ABCD, 3'd1, 5'd0, 0, 0, 0, 32'h0);
    run_txn(1'b1, 1'b0, 32'h8000_0100, 32'h1234_5678, 3'd2, 5'd0, 4, 0, 1, 32'h0);
    run_txn(1'b0, 1'b1, 32'h8000_0001, 32'h0, 3'd2, 5'd9, 0, 0, 0, 32'h0);
    run_txn(1'b0, 1'b1, 32'h8000_0008, 32'h0, 3'd2, 5'd10, 1, 2, 0, 32'h0);
    run_txn(1'b0, 1'b1, 32'h8000_000C, 32'h0, 3'd2, 5'd11, 0, 0, T - 1, 32'hCAFE_F00D);
    run_txn(1'b0, 1'b1, 32'h8000_0010, 32'h0, 3'd2, 5'd12, 2, 1, 1, 32'h5555_AAAA);
    run_txn(1'b0, 1'b1, 32'h8000_0014, 32'h0, 3'd2, 5'd0, 0, 0, 0, 32'hFFFF_FFFF);
    run_txn(1'b1, 1'b0, 32'h8000_0001, 32'h0000_00A5, 3'd0, 5'd0, 0, 0, 0, 32'h0);
    run_txn(1'b0, 1'b1, 32'h8000_0002, 32'h0, 3'd1, 5'd13, 0, 0, 0, 32'h8001_7FFF);
    run_txn(1'b0, 1'b1, 32'h8000_0002, 32'h0, 3'd5, 5'd14, 0, 0, 0, 32'h8001_7FFF);
    run_txn(1'b1, 1'b1, 32'h8000_0020, 32'h0BAD_CAFE, 3'd2, 5'd15, 1, 0, 0, 32'h0);
    run_txn(1'b0, 1'b1, 32'h8000_0024, 32'h0, 3'd3, 5'd16, 0, 0, 0, 32'h0);

    wait_idle();
    bus.ex_valid = 1'b1; bus.ex_wen = 1'b0; bus.ex_ren = 1'b0;
    tick();
    bus.ex_valid = 1'b0;
    chk("noop_busy", bus.busy, 1'b0);
    chk("noop_ex_ready", bus.ex_ready, 1'b1);

    wait_idle();
    bus.ex_valid = 1'b1; bus.ex_wen = 1'b0; bus.ex_ren = 1'b1;
    bus.ex_addr = 32'h8000_0040; bus.ex_func3 = 3'd2; bus.ex_rd = 5'd7;
    acc = cyc;
    push_ev(K_REQ, acc + 1, 1'b0, 32'h8000_0040, 0, 0, 0, 0);
    tick();
    scramble_ex();
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 32'h1357_9BDF;
    chk("rst_mid_busy", bus.busy, 1'b0);
    chk("rst_mid_ex_ready", bus.ex_ready, 1'b1);
    chk("rst_mid_wb", bus.wb_valid, 1'b0);
    tick();
    bus.mem_rsp_valid = 1'b0;
    repeat (3) tick();
    chk("rst_mid_no_wb", bus.wb_valid, 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      logic [2:0]  f3;
      bit          wen;
      bit          ren;
      int          r;
      int          mode;
      int          dly;
      wen = 1'($urandom);
      ren = wen ? ($urandom % 4 == 0) : 1'b1;
      f3 = ($urandom % 2 == 0) ? 3'd2 : 3'($urandom);
      a = 32'h8000_0000 | ($urandom & 32'h0000_0FFC);
      if ($urandom % 3 == 0) a[1:0] = 2'($urandom);
      r = $urandom % 20;
      mode = (r < 2) ? 1 : (r < 3) ? 2 : 0;
      dly = ($urandom % 8 == 0) ? T - 1 : int'($urandom % 3);
      run_txn(wen, ren, a, $urandom, f3, 5'($urandom), int'($urandom % 4), mode, dly, $urandom);
    end

    repeat (5) tick();
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
